// File: rtl/ctl_game.sv
// ============================================================================
//  ctl_game : Duck Hunt game-flow controller (ducks, rounds, game over)
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module ctl_game #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int MIN_HITS        = 6,
  parameter int FLIGHT_FRAMES   = 300,
  parameter int RESULT_FRAMES   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       start_btn,
  input  logic       pause_req,
  input  logic       hit,
  input  logic       no_ammo,
  output logic       duck_release,
  output logic       duck_escape,
  output logic       reset_score,
  output logic       reset_ammo,
  output logic       pause,
  output logic       looser,
  output logic       game_active,
  output logic [7:0] round_bcd,
  output logic [3:0] hits_in_round,
  output logic [3:0] ducks_left
);

  localparam logic [8:0] FLIGHT_LIM = 9'(FLIGHT_FRAMES);
  localparam logic [8:0] RESULT_LIM = 9'(RESULT_FRAMES);
  localparam logic [3:0] DUCKS_INIT = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0] HITS_MIN   = 4'(MIN_HITS);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SPAWN       = 3'd1,
    S_FLIGHT      = 3'd2,
    S_HIT_SHOW    = 3'd3,
    S_ESCAPE_SHOW = 3'd4,
    S_ROUND_END   = 3'd5,
    S_GAME_OVER   = 3'd6
  } state_t;

  state_t     state;
  logic [8:0] frame_cnt;
  logic       start_d;
  logic       start_rise;
  logic       live;
  logic       frozen;
  logic [7:0] round_inc;

  assign start_rise = start_btn & ~start_d;
  assign live       = (state == S_SPAWN) || (state == S_FLIGHT) ||
                      (state == S_HIT_SHOW) || (state == S_ESCAPE_SHOW);
  // Pause acts on the raw request so the cycle it rises is already frozen.
  assign frozen     = live & pause_req;
  assign round_inc  = (round_bcd == 8'h99)        ? round_bcd :
                      (round_bcd[3:0] == 4'd9)    ? {round_bcd[7:4] + 4'd1, 4'd0} :
                                                    {round_bcd[7:4], round_bcd[3:0] + 4'd1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      frame_cnt     <= 9'd0;
      start_d       <= 1'b0;
      duck_release  <= 1'b0;
      duck_escape   <= 1'b0;
      reset_score   <= 1'b0;
      reset_ammo    <= 1'b0;
      pause         <= 1'b0;
      looser        <= 1'b0;
      game_active   <= 1'b0;
      round_bcd     <= 8'h01;
      hits_in_round <= 4'd0;
      ducks_left    <= DUCKS_INIT;
    end else begin
      start_d      <= start_btn;
      duck_release <= 1'b0;
      duck_escape  <= 1'b0;
      reset_score  <= 1'b0;
      reset_ammo   <= 1'b0;
      pause        <= frozen;
      if (!frozen) begin
        case (state)
          S_IDLE, S_GAME_OVER: begin
            if (start_rise) begin
              reset_score   <= 1'b1;
              reset_ammo    <= 1'b1;
              round_bcd     <= 8'h01;
              hits_in_round <= 4'd0;
              ducks_left    <= DUCKS_INIT;
              looser        <= 1'b0;
              game_active   <= 1'b1;
              state         <= S_SPAWN;
            end
          end
          S_SPAWN: begin
            duck_release <= 1'b1;
            ducks_left   <= ducks_left - 4'd1;
            frame_cnt    <= 9'd0;
            state        <= S_FLIGHT;
          end
          S_FLIGHT: begin
            if (hit) begin
              hits_in_round <= (hits_in_round == 4'hF) ? 4'hF : hits_in_round + 4'd1;
              frame_cnt     <= 9'd0;
              state         <= S_HIT_SHOW;
            end else if (no_ammo || frame_cnt == FLIGHT_LIM) begin
              duck_escape <= 1'b1;
              frame_cnt   <= 9'd0;
              state       <= S_ESCAPE_SHOW;
            end else if (new_frame) begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
          S_HIT_SHOW, S_ESCAPE_SHOW: begin
            if (frame_cnt == RESULT_LIM) begin
              if (ducks_left == 4'd0) begin
                state <= S_ROUND_END;
              end else begin
                reset_ammo <= 1'b1;
                state      <= S_SPAWN;
              end
            end else if (new_frame) begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
          S_ROUND_END: begin
            if (hits_in_round >= HITS_MIN) begin
              round_bcd     <= round_inc;
              hits_in_round <= 4'd0;
              ducks_left    <= DUCKS_INIT;
              reset_ammo    <= 1'b1;
              state         <= S_SPAWN;
            end else begin
              looser      <= 1'b1;
              game_active <= 1'b0;
              state       <= S_GAME_OVER;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctl_game.sv
// Bench for ctl_game: two parameterisations share one stimulus stream and are
// checked every cycle against a game-rule model, plus literal spot checks.
`default_nettype none
`timescale 1ns/1ps

module tb_ctl_game;

  localparam int IDLE = 0, SP = 1, FL = 2, HS = 3, ES = 4, RE = 5, GO = 6;

  typedef struct {
    int st; int cnt; int sd;
    int rel; int esc; int rs; int ra; int pz; int lo; int act;
    int rnd; int hits; int left;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0, new_frame = 1'b0, start_btn = 1'b0, pause_req = 1'b0, hit = 1'b0, no_ammo = 1'b0;

  logic a_rel, a_esc, a_rs, a_ra, a_pz, a_lo, a_act;
  logic [7:0] a_round; logic [3:0] a_hits, a_left;
  logic b_rel, b_esc, b_rs, b_ra, b_pz, b_lo, b_act;
  logic [7:0] b_round; logic [3:0] b_hits, b_left;

  int vectors = 0, miscompares = 0;
  int n_rel = 0, n_esc = 0, n_rs = 0, n_ra = 0;
  bit armed = 0, seen_0910 = 0;
  logic [7:0] prev_b_round = 8'h00;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  ctl_game dut_a (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start_btn(start_btn), .pause_req(pause_req),
    .hit(hit), .no_ammo(no_ammo), .duck_release(a_rel), .duck_escape(a_esc), .reset_score(a_rs),
    .reset_ammo(a_ra), .pause(a_pz), .looser(a_lo), .game_active(a_act), .round_bcd(a_round),
    .hits_in_round(a_hits), .ducks_left(a_left)
  );

  ctl_game #(.DUCKS_PER_ROUND(2), .MIN_HITS(1), .FLIGHT_FRAMES(7), .RESULT_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start_btn(start_btn), .pause_req(pause_req),
    .hit(hit), .no_ammo(no_ammo), .duck_release(b_rel), .duck_escape(b_esc), .reset_score(b_rs),
    .reset_ammo(b_ra), .pause(b_pz), .looser(b_lo), .game_active(b_act), .round_bcd(b_round),
    .hits_in_round(b_hits), .ducks_left(b_left)
  );

  // One clock of the game rules; round kept as a plain integer 1..99.
  function automatic mdl_t step(mdl_t m, bit r, bit nf, bit sb, bit pr, bit h, bit na,
                                int dpr, int mh, int ff, int rf);
    mdl_t n;
    bit rise, live;
    n = m;
    rise = sb && (m.sd == 0);
    live = (m.st == SP) || (m.st == FL) || (m.st == HS) || (m.st == ES);
    n.rel = 0; n.esc = 0; n.rs = 0; n.ra = 0;
    n.sd = int'(sb);
    if (r) begin
      n = '{default: 0};
      n.st = IDLE; n.rnd = 1; n.left = dpr;
      return n;
    end
    n.pz = int'(live && pr);
    if (n.pz == 0) begin
      case (m.st)
        IDLE, GO: if (rise) begin
          n.rs = 1; n.ra = 1; n.rnd = 1; n.hits = 0; n.left = dpr; n.lo = 0; n.st = SP;
        end
        SP: begin n.rel = 1; n.left = m.left - 1; n.cnt = 0; n.st = FL; end
        FL: begin
          if (h) begin n.hits = (m.hits >= 15) ? 15 : m.hits + 1; n.cnt = 0; n.st = HS; end
          else if (na || m.cnt == ff) begin n.esc = 1; n.cnt = 0; n.st = ES; end
          else if (nf) n.cnt = m.cnt + 1;
        end
        HS, ES: begin
          if (m.cnt == rf) begin
            if (m.left == 0) n.st = RE;
            else begin n.ra = 1; n.st = SP; end
          end else if (nf) n.cnt = m.cnt + 1;
        end
        RE: begin
          if (m.hits >= mh) begin
            n.rnd = (m.rnd >= 99) ? 99 : m.rnd + 1; n.hits = 0; n.left = dpr; n.ra = 1; n.st = SP;
          end else begin
            n.lo = 1; n.st = GO;
          end
        end
        default: n.st = IDLE;
      endcase
    end
    n.act = int'(!(n.st == IDLE || n.st == GO));
    return n;
  endfunction

  function automatic logic [22:0] pack_m(mdl_t m);
    logic [7:0] bcd;
    bcd = 8'(((m.rnd / 10) * 16) + (m.rnd % 10));
    return {m.rel[0], m.esc[0], m.rs[0], m.ra[0], m.pz[0], m.lo[0], m.act[0], bcd, 4'(m.hits), 4'(m.left)};
  endfunction

  task automatic check(string name, logic [22:0] act, logic [22:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: dut=%h model=%h", name, $time, act, exp);
    end
  endtask

  task automatic lit(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    ma = step(ma, rst, new_frame, start_btn, pause_req, hit, no_ammo, 10, 6, 300, 60);
    mb = step(mb, rst, new_frame, start_btn, pause_req, hit, no_ammo, 2, 1, 7, 2);
    if (rst) armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("dut_a", {a_rel, a_esc, a_rs, a_ra, a_pz, a_lo, a_act, a_round, a_hits, a_left}, pack_m(ma));
      check("dut_b", {b_rel, b_esc, b_rs, b_ra, b_pz, b_lo, b_act, b_round, b_hits, b_left}, pack_m(mb));
      if (a_rel) n_rel++;
      if (a_esc) n_esc++;
      if (a_rs)  n_rs++;
      if (a_ra)  n_ra++;
      if (prev_b_round == 8'h09 && b_round == 8'h10) seen_0910 = 1;
      prev_b_round = b_round;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(int n);
    repeat (n) begin new_frame = 1; cyc(1); new_frame = 0; cyc(1); end
  endtask

  // Let the result display run out and the next duck get airborne.
  task automatic next_duck();
    frames(60); cyc(3);
  endtask

  task automatic play(bit do_hit);
    if (do_hit) hit = 1; else no_ammo = 1;
    cyc(1); hit = 0; no_ammo = 0; cyc(1);
    next_duck();
  endtask

  initial begin
    rst = 1; cyc(3); rst = 0; cyc(1);
    lit("reset_left", int'(a_left), 10);
    lit("reset_round", int'(a_round), 1);
    lit("reset_active", int'(a_act), 0);

    start_btn = 1; cyc(4); start_btn = 0;
    lit("start_rscore", n_rs, 1);
    lit("start_rammo", n_ra, 1);
    lit("start_release", n_rel, 1);
    lit("start_left", int'(a_left), 9);
    lit("start_round", int'(a_round), 1);

    frames(299); cyc(1);
    lit("no_early_escape", n_esc, 0);
    frames(1); cyc(1);
    lit("timeout_escape", n_esc, 1);
    frames(59);
    lit("show_hold", n_rel, 1);
    frames(1); cyc(2);
    lit("respawn_rammo", n_ra, 2);
    lit("respawn_release", n_rel, 2);

    hit = 1; no_ammo = 1; cyc(1); hit = 0; no_ammo = 0; cyc(1);
    lit("hit_wins_hits", int'(a_hits), 1);
    lit("hit_wins_noesc", n_esc, 1);
    next_duck();

    frames(50); pause_req = 1; cyc(1);
    lit("pause_level", int'(a_pz), 1);
    for (int i = 0; i < 100; i++) begin
      new_frame = 1; hit = (i % 10 == 3); cyc(1); new_frame = 0; hit = 0; cyc(1);
    end
    pause_req = 0; cyc(1);
    lit("pause_hit_ignored", int'(a_hits), 1);
    frames(249); cyc(1);
    lit("pause_no_escape", n_esc, 1);
    frames(1); cyc(1);
    lit("pause_resume_escape", n_esc, 2);
    next_duck();

    play(1); play(1); play(0); play(1); play(1); play(0); play(1);
    lit("round_adv", int'(a_round), 8'h02);
    lit("round_hits_clr", int'(a_hits), 0);
    lit("round_left_reload", int'(a_left), 9);

    for (int i = 0; i < 10; i++) play(i < 5);
    lit("gameover_looser", int'(a_lo), 1);
    lit("gameover_inactive", int'(a_act), 0);
    lit("gameover_round", int'(a_round), 8'h02);
    pause_req = 1; cyc(2);
    lit("gameover_nopause", int'(a_pz), 0);
    pause_req = 0;
    start_btn = 1; cyc(3); start_btn = 0;
    lit("restart_looser", int'(a_lo), 0);
    lit("restart_round", int'(a_round), 1);
    cyc(2); rst = 1; cyc(1);
    lit("midgame_rst_active", int'(a_act), 0);
    lit("midgame_rst_left", int'(a_left), 10);
    rst = 0; cyc(1);

    // Hit-heavy run drives the small-parameter instance up to round 99.
    rst = 1; cyc(2); rst = 0; start_btn = 1; cyc(2); start_btn = 0;
    for (int i = 0; i < 6000; i++) begin
      new_frame = 1'($urandom_range(0, 1));
      hit       = ($urandom_range(0, 2) == 0);
      start_btn = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    hit = 0; start_btn = 0; cyc(1);
    lit("b_round_09_to_10", int'(seen_0910), 1);
    lit("b_round_saturated", int'(b_round), 8'h99);

    for (int i = 0; i < 8000; i++) begin
      rst       = ($urandom_range(0, 599) == 0);
      new_frame = 1'($urandom_range(0, 1));
      hit       = ($urandom_range(0, 15) == 0);
      no_ammo   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)  start_btn = ~start_btn;
      if ($urandom_range(0, 39) == 0) pause_req = ~pause_req;
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
